// File: rtl/axi_lite_master.sv
//------------------------------------------------------------------------------
// Module  : axi_lite_master
// Brief   : Single-outstanding AXI4-Lite initiator. Turns a valid/ready
//           command stream into one AXI-Lite read or write per command and
//           returns exactly one response per command.
// Config  : ALIGN_CHECK_EN (define) - reject commands whose address is not
//           word aligned with resp 2'b10 and no AXI traffic.
// Ports   : clk, rstn            clock / async active-low reset
//           cmd_*                command stream in (valid/ready)
//           rsp_*                response stream out (valid/ready)
//           m_axi_aw*/w*/b*      AXI-Lite write address/data/response
//           m_axi_ar*/r*         AXI-Lite read address/data
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI-Lite write channels
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI-Lite read channels
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] C_IDLE         = 3'd0;
  localparam logic [2:0] C_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] C_WR_RESP      = 3'd2;
  localparam logic [2:0] C_RD_ADDR      = 3'd3;
  localparam logic [2:0] C_RD_DATA      = 3'd4;
  localparam logic [2:0] C_RSP          = 3'd5;

  logic [2:0] r_state;
  logic       r_aw_done;  // AW handshake already completed this write
  logic       r_w_done;   // W handshake already completed this write

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_misaligned;

  assign w_accept = cmd_valid & cmd_ready;
  assign w_aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_w_hs   = m_axi_wvalid & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes now,
  // so AW and W may finish in either order or in the same cycle.
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = (cmd_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= C_IDLE;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_accept) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            if (w_misaligned) begin
              // Rejected locally: no AXI traffic at all.
              rsp_rdata <= '0;
              rsp_resp  <= 2'b10;
              rsp_valid <= 1'b1;
              r_state   <= C_RSP;
            end else if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_aw_done     <= 1'b0;
              r_w_done      <= 1'b0;
              r_state       <= C_WR_ADDR_DATA;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              r_state       <= C_RD_ADDR;
            end
          end
        end

        C_WR_ADDR_DATA: begin
          if (w_aw_hs) begin
            m_axi_awvalid <= 1'b0;
            r_aw_done     <= 1'b1;
          end
          if (w_w_hs) begin
            m_axi_wvalid <= 1'b0;
            r_w_done     <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            m_axi_bready <= 1'b1;
            r_state      <= C_WR_RESP;
          end
        end

        C_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            r_state      <= C_RSP;
          end
        end

        C_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= C_RD_DATA;
          end
        end

        C_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            r_state      <= C_RSP;
          end
        end

        C_RSP: begin
          // rsp_* stay frozen until the consumer takes the response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= C_IDLE;
          end
        end

        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
